// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with integrated scoreboard.
// Included by regfile_scoreboard and regfile_sb via import regfile_pkg::*.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;
    localparam int REG_SP     = 29;
    localparam logic [31:0] SP_RST_VAL = 32'h0000_03FC;

    // Low bit of lane k in a flattened bus of w-bit lanes.
    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write tracker: one busy bit per GPR, set at issue, cleared at writeback or flush.
// Also keeps a registered count of busy registers and a sticky unexpected-writeback flag.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic                   iss_en,
    input  logic [ADDR_W-1:0]      iss_addr,
    input  logic                   flush,
    output logic [(2**ADDR_W)-1:0] busy,
    output logic [ADDR_W:0]        busy_cnt,
    output logic                   wb_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0] busy_nxt;
    logic [ADDR_W:0]  cnt_nxt;
    logic             err_set;

    // Issue is applied after the writeback clear so a same-cycle reissue keeps the bit set.
    always_comb begin
        busy_nxt = busy;
        if (wr_en && wr_addr != ZERO)
            busy_nxt[wr_addr] = 1'b0;
        if (flush)
            busy_nxt = '0;
        else if (iss_en && iss_addr != ZERO)
            busy_nxt[iss_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end

    assign err_set = wr_en && (wr_addr != ZERO) && !busy[wr_addr] && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
            wb_err   <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            if (err_set)
                wb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port GPR file with integrated RAW scoreboard; all state updates on posedge.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int                DATA_W = DEF_DATA_W,
    parameter int                ADDR_W = DEF_ADDR_W,
    parameter int                NUM_RD = 2,
    parameter int                SP_IDX = REG_SP,
    parameter logic [DATA_W-1:0] SP_RST = DATA_W'(SP_RST_VAL)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt,
    output logic                     wb_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= (i == SP_IDX) ? SP_RST : '0;
        end else if (wr_en && wr_addr != ZERO) begin
            mem[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt),
        .wb_err   (wb_err)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        localparam int ALO = lane_lo(k, ADDR_W);
        localparam int DLO = lane_lo(k, DATA_W);

        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign ra = rd_addr[ALO +: ADDR_W];

        always_comb begin
            data = (ra == ZERO) ? '0 : mem[ra];
            bsy  = busy[ra];
`ifdef REGFILE_BYPASS_EN
            // A same-cycle reissue of the written register still reports a hazard.
            if (wr_en && wr_addr == ra && ra != ZERO) begin
                data = wr_data;
                bsy  = iss_en && (iss_addr == ra) && !flush;
            end
`endif
        end

        assign rd_data[DLO +: DATA_W] = data;
        assign rd_busy[k]             = bsy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: reference model feeds an expectation queue each cycle.
// Honours REGFILE_BYPASS_EN when computing expected read-port values.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR*AW-1:0]   rd_addr;
    logic [NR*DW-1:0]   rd_data;
    logic [NR-1:0]      rd_busy;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic               iss_en;
    logic [AW-1:0]      iss_addr;
    logic               flush;
    logic [AW:0]        busy_cnt;
    logic               wb_err;

    regfile_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt),
        .wb_err   (wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] m_mem [32];
    logic [31:0] m_busy;
    logic        m_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val(e.tag, got, e.val);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++)
            m_mem[i] = (i == 29) ? 32'h0000_03FC : 32'h0;
        m_busy = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_update();
        if (wr_en && wr_addr != 0) begin
            if (!m_busy[wr_addr] && !flush)
                m_err = 1'b1;
            m_mem[wr_addr]  = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (flush)
            m_busy = '0;
        else if (iss_en && iss_addr != 0)
            m_busy[iss_addr] = 1'b1;
    endtask

    function automatic logic [31:0] exp_data(input logic [AW-1:0] a);
        if (a == 0)
            return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a)
            return wr_data;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0)
            return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a)
            return iss_en && (iss_addr == a) && !flush;
`endif
        return m_busy[a];
    endfunction

    function automatic logic [31:0] model_cnt();
        logic [31:0] c = 0;
        for (int i = 0; i < 32; i++)
            c += {31'b0, m_busy[i]};
        return c;
    endfunction

    task automatic set_in(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic ie, input logic [AW-1:0] ia, input logic fl,
                          input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia;
        flush    = fl;
        rd_addr  = {ra1, ra0};
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        logic [AW-1:0] a;
        if (!rst_n)
            model_reset();
        for (int k = 0; k < NR; k++) begin
            a = rd_addr[k*AW +: AW];
            push_exp($sformatf("rd_data%0d[%0d]", k, a), exp_data(a));
            push_exp($sformatf("rd_busy%0d[%0d]", k, a), {31'b0, exp_busy(a)});
        end
        #1;
        for (int k = 0; k < NR; k++) begin
            pop_check(rd_data[k*DW +: DW]);
            pop_check({31'b0, rd_busy[k]});
        end
        @(posedge clk);
        if (!rst_n)
            model_reset();
        else
            model_update();
        push_exp("busy_cnt", model_cnt());
        push_exp("wb_err", {31'b0, m_err});
        @(negedge clk);
        pop_check({26'b0, busy_cnt});
        pop_check({31'b0, wb_err});
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        model_reset();
        @(negedge clk);

        // Reset state across every address on both ports.
        for (int a = 0; a < 32; a++) begin
            set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'(a), 5'(31 - a));
            tick();
        end
        rst_n = 1'b1;

        // Issue 5, observe hazard, write it back.
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd29);
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
        tick();
        set_in(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
        tick();

        // Register 0 ignores writes and issues.
        set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        tick();

        // Same-cycle issue+write on 7, then a write to never-issued 9.
        set_in(1'b1, 5'd7, 32'h0000_1234, 1'b1, 5'd7, 1'b0, 5'd7, 5'd9);
        tick();
        set_in(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 1'b0, 5'd7, 5'd9);
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd9);
        tick();

        // Issue every register, then flush while issuing 3.
        for (int a = 1; a < 32; a++) begin
            set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b0, 5'(a), 5'd3);
            tick();
        end
        set_in(1'b1, 5'd12, 32'h0000_0C0C, 1'b1, 5'd3, 1'b1, 5'd3, 5'd12);
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd12);
        tick();

        // Write 8 while port 1 reads it, then observe after the edge.
        set_in(1'b1, 5'd8, 32'h0000_A5A5, 1'b0, 5'd0, 1'b0, 5'd8, 5'd8);
        tick();
        set_in(1'b1, 5'd8, 32'h0000_5A5A, 1'b1, 5'd8, 1'b0, 5'd0, 5'd8);
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd8, 5'd8);
        tick();

        // Random traffic over a small address range to force collisions.
        for (int n = 0; n < 80; n++) begin
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 9) == 0),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            tick();
        end

        // Reset mid-operation with write and issue active on other registers.
        set_in(1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd6, 1'b0, 5'd29, 5'd5);
        rst_n = 1'b0;
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd6);
        tick();
        rst_n = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd8, 5'd29);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
